// File: rtl/tdm_demux1to2_pkg.sv
// Shared definitions for the TDM 1-to-2 demultiplexer: FSM state encoding,
// channel constants and the slot-counter width helper.
package tdm_demux1to2_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Slot counter width for a frame of 2*width slots.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 1) ? 1 : $clog2(2 * width);
  endfunction

endpackage

// File: rtl/tdm_demux1to2_deser_shift.sv
// MSB-first deserialising shift register for one TDM channel.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (clears the register)
//   clr   - synchronous clear; if shift is also high the register restarts
//           holding only din (first bit of a fresh word)
//   shift - shift din in at the LSB
//   din   - serial data bit
//   q     - assembled word (first received bit ends up at the MSB)
module tdm_demux1to2_deser_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear-with-shift lets a resync slot start a new word on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= shift ? WIDTH'(din) : '0;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/tdm_demux1to2.sv
// Time-division 1-to-2 demultiplexer. De-interleaves a single-bit stream whose
// slots alternate ch0/ch1 and deserialises each channel into a WIDTH-bit word.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   din     - multiplexed serial data bit
//   en      - slot strobe; din/sync are sampled only when en=1
//   sync    - frame marker (slot 0), qualified by en
//   q0      - last complete channel-0 word (even slots)
//   q1      - last complete channel-1 word (odd slots)
//   valid   - 1-cycle pulse when q0/q1 update
//   sel_out - channel of the next expected slot
//   err     - 1-cycle pulse when sync arrives off a frame boundary
module tdm_demux1to2
  import tdm_demux1to2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             valid,
  output logic             sel_out,
  output logic             err
);

  localparam int unsigned      CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(2 * WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             restart_c;
  logic             slot_ch_c;
  logic             last_c;
  logic             err_d;
  logic             sel_d;
  logic             shift0_c, shift1_c;
  logic [WIDTH-1:0] sh0, sh1;
  logic [WIDTH-1:0] word0_c, word1_c;

  // FSM and slot counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, slot counter and per-slot strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;
    restart_c = 1'b0;
    slot_ch_c = CH0;
    last_c    = 1'b0;
    err_d     = 1'b0;

    if (en) begin
      case (state_q)
        ST_HUNT: begin
          if (sync) begin
            accept_c  = 1'b1;
            restart_c = 1'b1;
            state_d   = ST_RUN;
            cnt_d     = CNT_W'(1);
          end
        end
        ST_RUN: begin
          accept_c = 1'b1;
          if (sync && (cnt_q != '0)) begin
            // Misplaced sync: drop the partial frame and realign on this slot.
            restart_c = 1'b1;
            err_d     = 1'b1;
            cnt_d     = CNT_W'(1);
          end else begin
            slot_ch_c = cnt_q[0];
            if (cnt_q == LAST_SLOT) begin
              last_c = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    shift0_c = accept_c && (slot_ch_c == CH0);
    shift1_c = accept_c && (slot_ch_c == CH1);
    sel_d    = (state_d == ST_RUN) ? cnt_d[0] : 1'b0;
  end

  tdm_demux1to2_deser_shift #(.WIDTH(WIDTH)) u_ch0 (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart_c),
    .shift (shift0_c),
    .din   (din),
    .q     (sh0)
  );

  tdm_demux1to2_deser_shift #(.WIDTH(WIDTH)) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart_c),
    .shift (shift1_c),
    .din   (din),
    .q     (sh1)
  );

  // Words including the bit sampled on this edge, so the last slot lands in q.
  assign word0_c = shift0_c ? {sh0[WIDTH-2:0], din} : sh0;
  assign word1_c = shift1_c ? {sh1[WIDTH-2:0], din} : sh1;

  // Output registers and pulse generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0      <= '0;
      q1      <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      sel_out <= 1'b0;
    end else begin
      valid   <= last_c;
      err     <= err_d;
      sel_out <= sel_d;
      if (last_c) begin
        q0 <= word0_c;
        q1 <= word1_c;
      end
    end
  end

endmodule
